clk_div_sched: RTL and testbench

- Controller for the top-level clock-divider datapath (div2/div4/div8/div16 taps).
- Owns a free-running divide counter and a registered divided-clock output.
- Accepts divisor-change requests over a valid/ready handshake and applies each change only at counter wrap, so no runt pulse is ever produced.
- Sits between the pad-facing wrapper (ui_in-driven select) and the divided-clock consumers on uo_out.

---
 rtl/clk_div_sched.sv | 126 ++++++++++++
 tb/tb_clk_div_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Divider controller: free-running counter, registered divided clock, and a
// valid/ready divisor-change sequence that only switches on counter wrap.
module clk_div_sched #(
   parameter int unsigned CNT_W         = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned RESET_SEL     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [2:0] req_sel,
   output logic       req_ready,
   output logic [2:0] cur_sel,
   output logic       div_out,
   output logic       tick,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned SEL_W = 3;
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_WRAP = 2'd1,
      SETTLE    = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
   logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic               div_q, div_d;
   logic               tick_q, tick_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         cur_sel_q  <= SEL_W'(RESET_SEL);
         pend_sel_q <= '0;
         settle_q   <= '0;
         div_q      <= 1'b0;
         tick_q     <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         cur_sel_q  <= cur_sel_d;
         pend_sel_q <= pend_sel_d;
         settle_q   <= settle_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic; outputs are precomputed from next state so they register cleanly
   always_comb begin
      state_d    = state_q;
      count_d    = count_q + CNT_W'(1);
      cur_sel_d  = cur_sel_q;
      pend_sel_d = pend_sel_q;
      settle_d   = settle_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_sel > SEL_W'(CNT_W)) begin
                  err_d = 1'b1;
               end else begin
                  pend_sel_d = req_sel;
                  state_d    = WAIT_WRAP;
               end
            end
         end
         WAIT_WRAP: begin
            // All taps are low on the all-ones -> 0 edge, so switching here cannot glitch
            if (count_q == '1) begin
               cur_sel_d = pend_sel_q;
               settle_d  = SET_W'(SETTLE_CYCLES);
               state_d   = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q <= SET_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      div_d   = (cur_sel_d != '0) &&
                (|(count_d & (CNT_W'(1) << (cur_sel_d - SEL_W'(1)))));
      tick_d  = (count_d == '0);
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   assign req_ready = ready_q;
   assign cur_sel   = cur_sel_q;
   assign div_out   = div_q;
   assign tick      = tick_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: a cycle model pushes expected outputs,
// which are popped and compared one cycle later, plus directed latency checks.
module tb_clk_div_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic [2:0] req_sel;
   logic       req_ready;
   logic [2:0] cur_sel;
   logic       div_out, tick, busy, done, err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int sel;
      int div;
      int tick;
      int ready;
      int busy;
      int done;
      int err;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state (count, select, FSM 0=idle 1=wait 2=settle)
   int m_count, m_sel, m_state, m_pend, m_settle, m_done, m_err;

   clk_div_sched dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .cur_sel   (cur_sel),
      .div_out   (div_out),
      .tick      (tick),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.sel   = m_sel;
      e.div   = (m_sel == 0) ? 0 : ((m_count >> (m_sel - 1)) & 1);
      e.tick  = (m_count == 0) ? 1 : 0;
      e.ready = (m_state == 0) ? 1 : 0;
      e.busy  = (m_state != 0) ? 1 : 0;
      e.done  = m_done;
      e.err   = m_err;
      return e;
   endfunction

   task automatic model_reset();
      m_count = 0; m_sel = 1; m_state = 0; m_pend = 0; m_settle = 0;
      m_done = 0; m_err = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input int v, input int s);
      m_done = 0;
      m_err  = 0;
      if (m_state == 0) begin
         if (v != 0) begin
            if (s > 4) m_err = 1;
            else begin m_pend = s; m_state = 1; end
         end
      end else if (m_state == 1) begin
         if (m_count == 15) begin
            m_sel = m_pend; m_settle = 2; m_state = 2;
         end
      end else begin
         m_settle = m_settle - 1;
         if (m_settle == 0) begin m_state = 0; m_done = 1; end
      end
      m_count = (m_count + 1) % 16;
   endtask

   task automatic compare_all(input exp_t e);
      check("cur_sel",   int'(cur_sel),   e.sel);
      check("div_out",   int'(div_out),   e.div);
      check("tick",      int'(tick),      e.tick);
      check("req_ready", int'(req_ready), e.ready);
      check("busy",      int'(busy),      e.busy);
      check("done",      int'(done),      e.done);
      check("err",       int'(err),       e.err);
   endtask

   // One clock: model consumes current inputs, expectation is queued, then checked after the edge
   task automatic cycle();
      exp_t e;
      model_step(int'(req_valid), int'(req_sel));
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare_all(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_idle_count(input int c);
      int guard = 0;
      while (!(m_count == c && m_state == 0) && guard < 80) begin
         cycle();
         guard++;
      end
      check("wait_idle_count_timeout", guard < 80 ? 1 : 0, 1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         cycle();
         n++;
      end
      check("wait_done_timeout", n < 60 ? 1 : 0, 1);
   endtask

   task automatic request(input int s);
      req_valid = 1'b1;
      req_sel   = 3'(s);
      cycle();
      req_valid = 1'b0;
   endtask

   task automatic edges_until_sel(input int s, output int n);
      n = 1;
      while (int'(cur_sel) != s && n < 60) begin
         cycle();
         n++;
      end
   endtask

   initial begin
      int n;
      int ndone;
      req_valid = 1'b0;
      req_sel   = 3'd0;
      reset     = 1'b1;
      model_reset();
      #2;
      compare_all(model_out());
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Idle divide-by-2 with tick every 16 cycles
      run(34);

      // Accept sel=3 at count 5: switch on the following wrap, then two settle cycles
      wait_idle_count(5);
      request(3);
      edges_until_sel(3, n);
      check("switch_latency_at5", n, 11);
      wait_done(n);
      check("settle_len", n, 2);
      check("ready_with_done", int'(req_ready), 1);
      run(8);

      // Accept at count 15: the immediate wrap must not switch
      wait_idle_count(15);
      request(2);
      edges_until_sel(2, n);
      check("switch_latency_at15", n, 17);
      wait_done(n);

      // Illegal select is rejected with a single err pulse
      request(5);
      check("err_pulse", int'(err), 1);
      check("err_ready", int'(req_ready), 1);
      check("err_sel_kept", int'(cur_sel), 2);
      cycle();
      check("err_one_cycle", int'(err), 0);

      // Select 0 holds the output low
      request(0);
      wait_done(n);
      run(20);
      check("sel0_low", int'(div_out), 0);

      // Request during WAIT_WRAP is ignored
      request(4);
      req_valid = 1'b1;
      req_sel   = 3'd7;
      cycle();
      req_valid = 1'b0;
      wait_done(n);
      check("ignored_req_sel", int'(cur_sel), 4);

      // Async reset in the middle of WAIT_WRAP discards the pending switch
      request(2);
      run(3);
      check("busy_before_rst", int'(busy), 1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all(model_out());
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (done === 1'b1) ndone++;
      end
      check("no_done_after_rst", ndone, 0);
      check("sel_after_rst", int'(cur_sel), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
